// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg -- shared core defines for the write-back stage.
//   CORE_XLEN       : core datapath width
//   REG_ADDR_WIDTH  : architectural register index width
//   lsu_size_e      : load access size encodings (SZ_B/SZ_H/SZ_W/SZ_D)
// -----------------------------------------------------------------------------
package wb_stage_pkg;

  localparam int CORE_XLEN      = 64;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

endpackage : wb_stage_pkg

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if -- bundles the ALU result, LSU result handshake and register-file
// write port of the write-back stage.
//   alu_valid/alu_rd/alu_data           : single-cycle ALU result, no backpressure
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : LSU load result handshake
//   lsu_size/lsu_unsigned/lsu_offset    : load size, zero-extend flag, byte offset
//   rd_wen/rd_addr/rd_data              : registered register-file write port
//   wb_count                            : committed non-x0 write counter
// Modports: master = producer side (pipeline / bench), slave = wb_stage.
// -----------------------------------------------------------------------------
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) ();

  logic                      alu_valid;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [XLEN-1:0]           alu_data;

  logic                      lsu_valid;
  logic                      lsu_ready;
  logic [REG_ADDR_WIDTH-1:0] lsu_rd;
  logic [XLEN-1:0]           lsu_data;
  logic [1:0]                lsu_size;
  logic                      lsu_unsigned;
  logic [2:0]                lsu_offset;

  logic                      rd_wen;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic [XLEN-1:0]           rd_data;
  logic [63:0]               wb_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data, lsu_size, lsu_unsigned, lsu_offset,
    input  lsu_ready,
    input  rd_wen, rd_addr, rd_data, wb_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data, lsu_size, lsu_unsigned, lsu_offset,
    output lsu_ready,
    output rd_wen, rd_addr, rd_data, wb_count
  );

endinterface : wb_stage_if

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo -- small synchronous FIFO holding pending LSU results.
//   clk, rst            : clock, asynchronous active-high reset
//   push, push_data     : write request (ignored while full)
//   pop, pop_data       : read request (ignored while empty), head data
//   full, empty         : occupancy flags
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit so that
// full and empty are distinguishable when the index bits match.
// -----------------------------------------------------------------------------
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a resettable array would cost a flop reset per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule : wb_fifo

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back arbiter between the ALU and the load/store unit.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wb_stage_if.slave (ALU/LSU results in, register write port out)
// The ALU has strict priority. LSU results are always buffered in wb_fifo and
// drained in order whenever the ALU is idle, so a load accepted in cycle N is
// written in cycle N+2 at the earliest. Writes to x0 consume their slot but do
// not assert rd_wen or advance wb_count.
// Optional feature: define WB_LOAD_EXT_EN to align and sign/zero-extend load
// data before it enters the buffer; otherwise lsu_data is buffered raw.
// -----------------------------------------------------------------------------
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN           = CORE_XLEN,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  wb_stage_if.slave bus
);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]           data;
  } lsu_entry_t;

  localparam int ENTRY_W = $bits(lsu_entry_t);

`ifdef WB_LOAD_EXT_EN
  // Shift the addressed bytes down to bit 0, then extend to the full width.
  // Offsets that run past the doubleword simply yield whatever bytes remain.
  function automatic logic [XLEN-1:0] load_ext(
    input logic [XLEN-1:0] raw,
    input logic [1:0]      size,
    input logic            is_unsigned,
    input logic [2:0]      offset
  );
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] res;
    shifted = raw >> {offset, 3'b000};
    case (lsu_size_e'(size))
      SZ_B:    res = is_unsigned ? {{(XLEN-8){1'b0}},  shifted[7:0]}
                                 : {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      SZ_H:    res = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                 : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      SZ_W:    res = is_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                 : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: res = shifted;
    endcase
    return res;
  endfunction
`endif

  lsu_entry_t                push_entry;
  lsu_entry_t                head_entry;
  logic [ENTRY_W-1:0]        head_bits;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;

  logic                      sel_valid;
  logic [REG_ADDR_WIDTH-1:0] sel_rd;
  logic [XLEN-1:0]           sel_data;
  logic                      commit;

  // ---------------------------------------------------------------------------
  // LSU side: accept whenever the buffer has room.
  // ---------------------------------------------------------------------------
  assign bus.lsu_ready = !fifo_full;
  assign fifo_push     = bus.lsu_valid && !fifo_full;
  assign push_entry.rd = bus.lsu_rd;

`ifdef WB_LOAD_EXT_EN
  assign push_entry.data = load_ext(bus.lsu_data, bus.lsu_size, bus.lsu_unsigned,
                                    bus.lsu_offset);
`else
  assign push_entry.data = bus.lsu_data;
  logic unused_ext;
  assign unused_ext = ^{bus.lsu_size, bus.lsu_unsigned, bus.lsu_offset};
`endif

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_entry = lsu_entry_t'(head_bits);

  // ---------------------------------------------------------------------------
  // Arbitration: ALU first, otherwise the oldest buffered load.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    fifo_pop  = 1'b0;
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = bus.alu_rd;
      sel_data  = bus.alu_data;
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = head_entry.rd;
      sel_data  = head_entry.data;
    end
  end

  // A selected x0 result is consumed but never committed.
  assign commit = sel_valid && (sel_rd != '0);

  // ---------------------------------------------------------------------------
  // Registered write port and commit counter. wb_count advances together with
  // rd_wen so it already includes the write currently on the port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_wen   <= 1'b0;
      bus.rd_addr  <= '0;
      bus.rd_data  <= '0;
      bus.wb_count <= '0;
    end else begin
      bus.rd_wen <= commit;
      if (commit) begin
        bus.rd_addr <= sel_rd;
        bus.rd_data <= sel_data;
      end
      bus.wb_count <= bus.wb_count + 64'(commit);
    end
  end

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage (XLEN=64, depth 2).
// A reference model holds pending loads in a queue: each cycle the ALU result
// wins if valid, else the oldest queued load is written; a load is accepted
// only while fewer than DEPTH are queued, and becomes eligible the next cycle.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  logic clk;
  logic rst;

  wb_stage_if #(.XLEN(64)) bus ();

  wb_stage #(
    .XLEN           (64),
    .LSU_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  ent_t        mq[$];
  logic [63:0] cnt_exp = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected value a load contributes to the register file.
  function automatic logic [63:0] ref_ext(input logic [63:0] data, input logic [1:0] size,
                                          input logic uns, input logic [2:0] off);
`ifdef WB_LOAD_EXT_EN
    int          nbits;
    logic [63:0] v;
    logic [63:0] mask;
    nbits = 8 * (1 << size);
    v     = data >> (8 * off);
    if (nbits == 64) return v;
    mask = (64'd1 << nbits) - 64'd1;
    v    = v & mask;
    if (!uns && v[nbits-1]) v = v | ~mask;
    return v;
`else
    return data;
`endif
  endfunction

  // One clock: drive inputs, predict, tick, compare.
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [63:0] ld,
                       input logic [1:0] sz, input logic un, input logic [2:0] off);
    logic        exp_ready;
    logic        sel;
    logic        exp_wen;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
    ent_t        e;
    bus.alu_valid    = av;
    bus.alu_rd       = ar;
    bus.alu_data     = ad;
    bus.lsu_valid    = lv;
    bus.lsu_rd       = lr;
    bus.lsu_data     = ld;
    bus.lsu_size     = sz;
    bus.lsu_unsigned = un;
    bus.lsu_offset   = off;
    exp_ready = (mq.size() < DEPTH);
    #1;
    check("lsu_ready", 64'(bus.lsu_ready), 64'(exp_ready));
    sel      = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    if (av) begin
      sel = 1'b1; exp_addr = ar; exp_data = ad;
    end else if (mq.size() > 0) begin
      e   = mq.pop_front();
      sel = 1'b1; exp_addr = e.rd; exp_data = e.data;
    end
    exp_wen = sel && (exp_addr != 5'd0);
    if (exp_wen) cnt_exp = cnt_exp + 64'd1;
    if (lv && exp_ready) begin
      e.rd   = lr;
      e.data = ref_ext(ld, sz, un, off);
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    check("rd_wen", 64'(bus.rd_wen), 64'(exp_wen));
    if (exp_wen) begin
      check("rd_addr", 64'(bus.rd_addr), 64'(exp_addr));
      check("rd_data", bus.rd_data, exp_data);
    end
    check("wb_count", bus.wb_count, cnt_exp);
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 3'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.lsu_size = '0; bus.lsu_unsigned = 1'b0; bus.lsu_offset = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wen",   64'(bus.rd_wen), 64'd0);
    check("reset_addr",  64'(bus.rd_addr), 64'd0);
    check("reset_data",  bus.rd_data, 64'd0);
    check("reset_count", bus.wb_count, 64'd0);
    rst = 1'b0;
    #1;
    check("reset_ready", 64'(bus.lsu_ready), 64'd1);

    // ALU only.
    cycle(1'b1, 5'd5, 64'h0123456789ABCDEF, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 3'd0);
    check("alu_count_one", bus.wb_count, 64'd1);
    idle();

    // x0 write suppressed.
    cycle(1'b1, 5'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 3'd0);
    check("x0_count_same", bus.wb_count, 64'd1);

    // Contention: ALU x1 now, LSU x2 one cycle later.
    cycle(1'b1, 5'd1, 64'h1111, 1'b1, 5'd2, 64'h2222, 2'd3, 1'b0, 3'd0);
    check("contend_x1", 64'(bus.rd_addr), 64'd1);
    idle();
    check("contend_x2", 64'(bus.rd_addr), 64'd2);
    idle();

    // Backpressure: ALU busy, three loads offered; the third is held.
    cycle(1'b1, 5'd10, 64'hA0, 1'b1, 5'd20, 64'hB0, 2'd3, 1'b0, 3'd0);
    cycle(1'b1, 5'd11, 64'hA1, 1'b1, 5'd21, 64'hB1, 2'd3, 1'b0, 3'd0);
    cycle(1'b1, 5'd12, 64'hA2, 1'b1, 5'd22, 64'hB2, 2'd3, 1'b0, 3'd0);
    cycle(1'b1, 5'd13, 64'hA3, 1'b1, 5'd22, 64'hB2, 2'd3, 1'b0, 3'd0);
    cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd22, 64'hB2, 2'd3, 1'b0, 3'd0);
    check("bp_first_drain", 64'(bus.rd_addr), 64'd20);
    cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd22, 64'hB2, 2'd3, 1'b0, 3'd0);
    check("bp_second_drain", 64'(bus.rd_addr), 64'd21);
    repeat (3) idle();
    check("bp_third", bus.rd_data, 64'hB2);

    // Load extension (raw pass-through when the feature is compiled out).
    cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h0000000080000000, 2'd2, 1'b0, 3'd0);
    idle();
`ifdef WB_LOAD_EXT_EN
    check("ext_w_signed", bus.rd_data, 64'hFFFFFFFF80000000);
`else
    check("ext_raw", bus.rd_data, 64'h0000000080000000);
`endif
    cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h0000000080000000, 2'd2, 1'b1, 3'd0);
    idle();
    check("ext_w_unsigned", bus.rd_data, 64'h0000000080000000);
    cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h0000000080000000, 2'd0, 1'b0, 3'd3);
    idle();
`ifdef WB_LOAD_EXT_EN
    check("ext_b_off3", bus.rd_data, 64'hFFFFFFFFFFFFFF80);
`else
    check("ext_b_raw", bus.rd_data, 64'h0000000080000000);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
            {$urandom, $urandom},
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
            {$urandom, $urandom},
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)));
    end
    repeat (3) idle();

    // Reset mid-operation with two loads buffered.
    cycle(1'b1, 5'd3, 64'hC3, 1'b1, 5'd8, 64'hD8, 2'd3, 1'b0, 3'd0);
    cycle(1'b1, 5'd4, 64'hC4, 1'b1, 5'd9, 64'hD9, 2'd3, 1'b0, 3'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_wen",   64'(bus.rd_wen), 64'd0);
    check("midrst_count", bus.wb_count, 64'd0);
    check("midrst_data",  bus.rd_data, 64'd0);
    mq.delete();
    cnt_exp = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_ready", 64'(bus.lsu_ready), 64'd1);
    idle();
    idle();
    check("midrst_no_write", bus.wb_count, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_wb_stage

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter LSU_FIFO_DEPTH, default 2, LSU result buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports alu_valid/alu_rd/alu_data  input  1/5/XLEN  single-cycle ALU result, no backpressure.
REQ-006 SHALL have ports lsu_valid/lsu_rd/lsu_data  input  1/5/XLEN  raw load doubleword from LSU.
REQ-007 SHALL have ports lsu_size/lsu_unsigned/lsu_offset  input  2/1/3  access size (0=B,1=H,2=W,3=D), zero-extend flag, byte offset.
REQ-008 SHALL have port lsu_ready  output  1  LSU result accepted when lsu_valid&&lsu_ready.
REQ-009 SHALL have ports rd_wen/rd_addr/rd_data  output  1/5/XLEN  register-file write port.
REQ-010 SHALL have port wb_count  output  64  count of committed non-x0 writes.

Function
REQ-011 SHALL register rd_wen/rd_addr/rd_data: a result selected in cycle N appears on the write port in cycle N+1, for exactly one cycle.
REQ-012 SHALL give ALU strict priority; when alu_valid=1 the ALU result is selected that cycle.
REQ-013 SHALL push accepted LSU results into a FIFO of LSU_FIFO_DEPTH entries, in order.
REQ-014 SHALL pop the FIFO head when alu_valid=0 and FIFO non-empty.
REQ-015 SHALL drive lsu_ready = !full; push and pop in the same cycle while full SHALL NOT be allowed (ready stays 0 while full).
REQ-016 SHALL support simultaneous push and pop when not full; occupancy unchanged, order preserved.
REQ-017 SHALL wrap FIFO pointers modulo LSU_FIFO_DEPTH with one extra wrap bit for full/empty.
REQ-018 SHALL never bypass the FIFO: an LSU result accepted in cycle N is written at earliest cycle N+2.
REQ-019 SHALL suppress writes with rd=0: rd_wen=0, wb_count unchanged, entry still consumed.
REQ-020 SHALL increment wb_count by 1 on each cycle rd_wen=1, wrapping at 2^64-1 to 0.
REQ-021 SHALL ignore lsu_valid while lsu_ready=0 (no push).

Reset
REQ-022 SHALL on rst force rd_wen=0, rd_addr=0, rd_data=0, wb_count=0, FIFO empty, lsu_ready=1 after release.
REQ-023 SHALL discard FIFO contents and any pending write when rst asserts mid-operation; no write in the cycle after release.

Configuration
REQ-024 SHALL, with WB_LOAD_EXT_EN defined, shift lsu_data right by 8*lsu_offset then sign- or zero-extend per lsu_size/lsu_unsigned before FIFO push.
REQ-025 SHALL, without WB_LOAD_EXT_EN, push lsu_data unmodified; lsu_size/lsu_unsigned/lsu_offset unused.
REQ-026 SHALL treat misaligned offsets (offset+size beyond 8 bytes) as don't-care-data but still write the entry.

Structure
REQ-027 SHALL take XLEN and REG_ADDR_WIDTH from the shared core defines file; add size encodings SZ_B/SZ_H/SZ_W/SZ_D there.
REQ-028 SHALL implement the buffer as sub-module wb_fifo (parameterised width and depth, push/pop/full/empty).
REQ-029 SHALL keep load extension as a function/block inside wb_stage, not a separate module.

Verification
REQ-030 ALU only: alu_valid=1, rd=5, data=0x0123456789ABCDEF -> next cycle rd_wen=1, rd_addr=5, same data, wb_count=1.
REQ-031 Contention: ALU rd=1 and LSU rd=2 valid same cycle -> x1 written cycle N+1, x2 written N+2.
REQ-032 Backpressure: alu_valid held 1, three LSU pushes -> lsu_ready=0 after 2 accepted; third held; on alu_valid=0 the two drain in order, then third accepted.
REQ-033 x0: ALU rd=0 data=0xFFFFFFFFFFFFFFFF -> rd_wen stays 0, wb_count unchanged.
REQ-034 Extension (WB_LOAD_EXT_EN): lsu_data=0x00000000_80000000, size=W, offset=0, unsigned=0 -> 0xFFFFFFFF80000000; unsigned=1 -> 0x0000000080000000; size=B, offset=3 -> 0xFFFFFFFFFFFFFF80.
REQ-035 Reset mid-op: FIFO holding 2 entries, assert rst -> no writes after release, lsu_ready=1, wb_count=0.
